dff: RTL and testbench

- Parameterizable positive-edge D-type register: captures D on every rising clk edge and presents it on Q.
- Asynchronous active-high reset forces Q to a parameterized reset value.
- Leaf storage primitive used throughout the datapath and control logic wherever a single-cycle registered delay is needed.
- Default configuration is a 1-bit flop with reset value 0.

---
 rtl/dff.sv | 41 ++++
 tb/tb_dff.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dff.sv
// Parameterizable D-type register chain: STAGES cascaded flops, async active-high reset to RESET_VALUE.
// Optional inverted output Qn is enabled by defining DFF_QN_EN.
module dff #(
  parameter int                 WIDTH       = 1,
  parameter logic [WIDTH-1:0]   RESET_VALUE = '0,
  parameter int                 STAGES      = 1
) (
  input  logic             clk,
  input  logic             sync_reset,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q
`ifdef DFF_QN_EN
  ,
  output logic [WIDTH-1:0] Qn
`endif
);

  logic [WIDTH-1:0] stage_q [STAGES];

  // Reset is asynchronous despite the port name; it clears every stage so in-flight data is discarded.
  always_ff @(posedge clk or posedge sync_reset) begin
    if (sync_reset) begin
      for (int i = 0; i < STAGES; i++) begin
        stage_q[i] <= RESET_VALUE;
      end
    end else begin
      stage_q[0] <= D;
      for (int i = 1; i < STAGES; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign Q = stage_q[STAGES-1];

`ifdef DFF_QN_EN
  // Inverted view of the final stage, not a separate register chain.
  assign Qn = ~stage_q[STAGES-1];
`endif

endmodule

// File: tb/tb_dff.sv
// Bench for dff: three instances (default, 8-bit with A5 reset, 3-stage 4-bit) checked through expected queues.
// Define DFF_QN_EN to also check the inverted output of the default instance.
module tb_dff;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  // default instance: WIDTH=1, RESET_VALUE=0, STAGES=1
  logic       rst0;
  logic [0:0] d0;
  logic [0:0] q0;
`ifdef DFF_QN_EN
  logic [0:0] qn0;
`endif

  // 8-bit instance with non-zero reset value
  logic       rst8;
  logic [7:0] d8;
  logic [7:0] q8;

  // 3-stage 4-bit instance
  logic       rst3;
  logic [3:0] d3;
  logic [3:0] q3;

  dff u_dff0 (
    .clk        (clk),
    .sync_reset (rst0),
    .D          (d0),
    .Q          (q0)
`ifdef DFF_QN_EN
    ,
    .Qn         (qn0)
`endif
  );

  dff #(.WIDTH(8), .RESET_VALUE(8'hA5), .STAGES(1)) u_dff8 (
    .clk        (clk),
    .sync_reset (rst8),
    .D          (d8),
    .Q          (q8)
`ifdef DFF_QN_EN
    ,
    .Qn         ()
`endif
  );

  dff #(.WIDTH(4), .RESET_VALUE(4'h0), .STAGES(3)) u_dff3 (
    .clk        (clk),
    .sync_reset (rst3),
    .D          (d3),
    .Q          (q3)
`ifdef DFF_QN_EN
    ,
    .Qn         ()
`endif
  );

  // scoreboard state
  logic [0:0] exp0_q[$];
  logic [7:0] exp8_q[$];
  logic [3:0] exp3_q[$];
  int  checks = 0;
  int  errors = 0;
  bit  act0 = 1'b0, act8 = 1'b0, act3 = 1'b0;
  bit  done0 = 1'b0, done8 = 1'b0, done3 = 1'b0;
  event strb0_ev, strb8_ev, strb3_ev;

  // hand-computed vectors
  logic [0:0] d0_tab [8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
  logic [0:0] e0_tab [8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
  logic [3:0] d3_tab [16] = '{4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h2,
                              4'h3, 4'h4, 4'h0, 4'h0, 4'h0, 4'h7, 4'h9, 4'hA};
  logic [3:0] e3_tab [16] = '{4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0,
                              4'h1, 4'h2, 4'h3, 4'h4, 4'h0, 4'h0, 4'h0, 4'h7};

  // ---------------- monitor ----------------
  task automatic check0(input string name);
    logic [0:0] e;
    checks++;
    if (exp0_q.size() == 0) begin
      errors++;
      $display("FAIL %s t=%0t: q0=%b but no expected value queued", name, $time, q0);
    end else begin
      e = exp0_q.pop_front();
      if (q0 !== e) begin
        errors++;
        $display("FAIL %s t=%0t: q0=%b expected %b", name, $time, q0, e);
      end
`ifdef DFF_QN_EN
      checks++;
      if (qn0 !== ~e) begin
        errors++;
        $display("FAIL %s_qn t=%0t: qn0=%b expected %b", name, $time, qn0, ~e);
      end
`endif
    end
  endtask

  task automatic check8(input string name);
    logic [7:0] e;
    checks++;
    if (exp8_q.size() == 0) begin
      errors++;
      $display("FAIL %s t=%0t: q8=%h but no expected value queued", name, $time, q8);
    end else begin
      e = exp8_q.pop_front();
      if (q8 !== e) begin
        errors++;
        $display("FAIL %s t=%0t: q8=%h expected %h", name, $time, q8, e);
      end
    end
  endtask

  task automatic check3(input string name);
    logic [3:0] e;
    checks++;
    if (exp3_q.size() == 0) begin
      errors++;
      $display("FAIL %s t=%0t: q3=%h but no expected value queued", name, $time, q3);
    end else begin
      e = exp3_q.pop_front();
      if (q3 !== e) begin
        errors++;
        $display("FAIL %s t=%0t: q3=%h expected %h", name, $time, q3, e);
      end
    end
  endtask

  always @(posedge clk) begin
    #2;
    if (act0) check0("q0_edge");
    if (act8) check8("q8_edge");
    if (act3) check3("q3_edge");
  end

  always @(strb0_ev) check0("q0_async");
  always @(strb8_ev) check8("q8_async");
  always @(strb3_ev) check3("q3_async");

  // ---------------- stimulus: default instance ----------------
  initial begin
    rst0 = 1'b1;
    d0   = 1'b1;
    act0 = 1'b1;
    exp0_q.push_back(1'b0);               // edge 10: held in reset despite D=1
    @(negedge clk);
    exp0_q.push_back(1'b0);               // edge 30
    @(negedge clk);
    rst0 = 1'b0;                          // release at 40
    for (int j = 0; j < 8; j++) begin
      d0 = d0_tab[j];
      exp0_q.push_back(e0_tab[j]);        // edges 50..190
      @(negedge clk);
    end
    #5;                                   // t=205, Q=1, midway between edges
    rst0 = 1'b1;
    #1;
    exp0_q.push_back(1'b0);
    ->strb0_ev;
    exp0_q.push_back(1'b0);               // edge 210 under reset
    @(negedge clk);
    exp0_q.push_back(1'b0);
    ->strb0_ev;
    exp0_q.push_back(1'b0);               // edge 230 under reset
    @(negedge clk);
    rst0 = 1'b0;
    d0   = 1'b0;
    exp0_q.push_back(1'b0);               // edge 250
    @(posedge clk);
    #5;
    act0  = 1'b0;
    done0 = 1'b1;
  end

  // ---------------- stimulus: 8-bit instance ----------------
  initial begin
    rst8 = 1'b1;
    d8   = 8'h00;
    act8 = 1'b1;
    #5;
    exp8_q.push_back(8'hA5);              // before any clock edge
    ->strb8_ev;
    exp8_q.push_back(8'hA5);              // edge 10
    @(negedge clk);
    d8 = 8'h3C;
    exp8_q.push_back(8'hA5);              // edge 30, still in reset
    @(negedge clk);
    rst8 = 1'b0;
    exp8_q.push_back(8'h3C);              // edge 50, first edge after release
    @(negedge clk);
    exp8_q.push_back(8'h3C);              // edge 70
    @(negedge clk);
    d8 = 8'h5A;
    exp8_q.push_back(8'h5A);              // edge 90
    @(negedge clk);
    d8 = 8'hFF;
    exp8_q.push_back(8'hFF);              // edge 110
    @(posedge clk);
    #5;
    act8  = 1'b0;
    done8 = 1'b1;
  end

  // ---------------- stimulus: 3-stage instance ----------------
  initial begin
    rst3 = 1'b1;
    d3   = 4'h0;
    act3 = 1'b1;
    exp3_q.push_back(4'h0);               // edge 10
    @(negedge clk);
    exp3_q.push_back(4'h0);               // edge 30
    @(negedge clk);
    rst3 = 1'b0;
    for (int j = 0; j < 16; j++) begin
      d3 = d3_tab[j];
      exp3_q.push_back(e3_tab[j]);        // edges 50..350
      if (j != 15) @(negedge clk);
    end
    @(posedge clk);
    #5;                                   // t=355, Q=7 with 9 and A in flight
    rst3 = 1'b1;
    #1;
    exp3_q.push_back(4'h0);
    ->strb3_ev;
    exp3_q.push_back(4'h0);               // edge 370 under reset
    @(negedge clk);
    @(negedge clk);
    rst3 = 1'b0;
    d3   = 4'h0;
    exp3_q.push_back(4'h0);               // edge 390
    @(negedge clk);
    exp3_q.push_back(4'h0);               // edge 410
    @(negedge clk);
    exp3_q.push_back(4'h0);               // edge 430
    @(posedge clk);
    #5;
    act3  = 1'b0;
    done3 = 1'b1;
  end

  // ---------------- completion and report ----------------
  initial begin
    for (int c = 0; c < 60 && !(done0 && done8 && done3); c++) @(negedge clk);
    checks++;
    if (!(done0 && done8 && done3)) begin
      errors++;
      $display("FAIL timeout: done0=%0d done8=%0d done3=%0d expected all 1", done0, done8, done3);
    end
    #5;
    checks++;
    if (exp0_q.size() + exp8_q.size() + exp3_q.size() != 0) begin
      errors++;
      $display("FAIL leftover: %0d expected values never checked, expected 0",
               exp0_q.size() + exp8_q.size() + exp3_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
